// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared opcodes, state encoding and datapath select codes for the multicycle controller
// Contents: opcode/funct constants, state_e (fixed 4-bit codes), alu_src_b / alu_op / pc_source
// encodings, the one-hot instruction class and the bundle of control outputs.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] FUNCT_JR  = 6'b001000;

    localparam logic [1:0] ALUB_B       = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG_A  = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_RD    = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WR    = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_JR        = 4'd12
    } state_e;

    typedef struct packed {
        logic rtype;
        logic jr;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic addi;
        logic j;
        logic illegal;
    } instr_class_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - controller <-> datapath/memory signal bundle
// master: the controller (takes opcode/funct/zero/mem_ready, drives every select, enable and status).
// slave:  the datapath side (drives instruction fields and flags, observes the controls).
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mips_opcode_decode.sv
// rtl/mips_opcode_decode.sv - combinational opcode/funct to one-hot instruction class
// Ports: opcode (IR[31:26]), funct (IR[5:0]) in; cls one-hot class out (illegal when nothing matches).
module mips_opcode_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                // jr lives inside the R-type space; split it out so rtype and jr stay mutually exclusive
                if (funct == FUNCT_JR) cls.jr = 1'b1;
                else                   cls.rtype = 1'b1;
            end
            OP_LW:   cls.lw   = 1'b1;
            OP_SW:   cls.sw   = 1'b1;
            OP_BEQ:  cls.beq  = 1'b1;
            OP_BNE:  cls.bne  = 1'b1;
            OP_ADDI: cls.addi = 1'b1;
            OP_J:    cls.j    = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM (fetch/decode/execute/memory/writeback)
// Ports: clk, reset_n (synchronous, active-low); bus (master modport) carrying opcode/funct/zero/
// mem_ready in and all datapath selects/enables, instr_done, illegal_op and debug state out.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int RESET_VECTOR_SEL = 0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    mips_multicycle_ctrl_if.master        bus
);

    if (RESET_VECTOR_SEL != 0) begin : g_bad_reset_vector_sel
        $error("RESET_VECTOR_SEL must be 0");
    end

    state_e       state_q;
    state_e       state_d;
    instr_class_t cls;
    ctrl_t        ctrl;
    ctrl_t        ctrl_out;

    mips_opcode_decode u_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .cls    (cls)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_FETCH;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (bus.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (cls.lw || cls.sw)        state_d = ST_MEM_ADDR;
                else if (cls.rtype)          state_d = ST_R_EXEC;
                else if (cls.jr)             state_d = ST_JR;
                else if (cls.beq || cls.bne) state_d = ST_BRANCH;
                else if (cls.j)              state_d = ST_JUMP;
                else if (cls.addi)           state_d = ST_ADDI_EXEC;
                else                         state_d = ST_FETCH;
            end
            ST_MEM_ADDR:  state_d = cls.sw ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:    if (bus.mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WR:    if (bus.mem_ready) state_d = ST_FETCH;
            ST_R_EXEC:    state_d = ST_R_WB;
            ST_ADDI_EXEC: state_d = ST_ADDI_WB;
            ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB, ST_JR:
                          state_d = ST_FETCH;
            default:      state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b  = ALUB_IMM_SH2;
                ctrl.illegal_op = cls.illegal;
                ctrl.instr_done = cls.illegal;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
                // beq goes through the datapath's zero gate; bne is resolved here since that gate only knows "equal"
                ctrl.pc_write_cond = cls.beq;
                ctrl.pc_write      = cls.bne & ~bus.zero;
            end
            ST_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JR: begin
                ctrl.pc_source  = PCSRC_REG_A;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Reset masks the outputs immediately, before the first reset edge has moved the state register
    assign ctrl_out = reset_n ? ctrl : '0;

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.i_or_d        = ctrl_out.i_or_d;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.instr_done    = ctrl_out.instr_done;
    assign bus.illegal_op    = ctrl_out.illegal_op;
    assign bus.state         = reset_n ? state_q : ST_FETCH;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus_if ();

    mips_multicycle_ctrl #(.RESET_VECTOR_SEL(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    localparam int C_R = 0, C_JR = 1, C_LW = 2, C_SW = 3, C_BEQ = 4, C_BNE = 5,
                   C_ADDI = 6, C_J = 7, C_ILL = 8;

    typedef int iq_t[$];

    // directed-stimulus overrides consumed by the driver
    bit          mr_q[$];
    logic [11:0] op_q[$];
    bit          force_zero = 1'b0;
    bit          zero_val   = 1'b0;

    // reference model: the state path of the current instruction and a position in it
    iq_t         seq;
    int          idx = 0;
    int          cls = C_ILL;
    int          lat = 0;
    int          waits = 0;
    int          icyc = 0;
    logic [5:0]  cur_op = '0;
    logic [5:0]  cur_fn = '0;

    // snapshot of the final cycle of a directed instruction
    logic       s_pcw, s_pcwc, s_ill;
    logic [1:0] s_psrc;
    logic [3:0] s_state;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'd0) return (fn == 6'd8) ? C_JR : C_R;
        case (op)
            6'd35:   return C_LW;
            6'd43:   return C_SW;
            6'd4:    return C_BEQ;
            6'd5:    return C_BNE;
            6'd8:    return C_ADDI;
            6'd2:    return C_J;
            default: return C_ILL;
        endcase
    endfunction

    function automatic iq_t path_of(input int c);
        case (c)
            C_R:    return '{0, 1, 6, 7};
            C_JR:   return '{0, 1, 12};
            C_LW:   return '{0, 1, 2, 3, 4};
            C_SW:   return '{0, 1, 2, 5};
            C_BEQ:  return '{0, 1, 8};
            C_BNE:  return '{0, 1, 8};
            C_ADDI: return '{0, 1, 10, 11};
            C_J:    return '{0, 1, 9};
            default: return '{0, 1};
        endcase
    endfunction

    function automatic int latency_of(input int c);
        case (c)
            C_LW:                return 5;
            C_R, C_SW, C_ADDI:   return 4;
            C_ILL:               return 2;
            default:             return 3;
        endcase
    endfunction

    // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,
    //  alu_src_a,alu_src_b[2],alu_op[2],pc_source[2],instr_done,illegal_op,state[4]}
    function automatic logic [21:0] exp_vec(input int st, input int c, input bit z, input bit mr, input bit rstn);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, asa = 0;
        bit done = 0, ill = 0;
        bit [1:0] asb = 0, aop = 0, psrc = 0;
        if (!rstn) return '0;
        case (st)
            0:  begin mrd = 1; asb = 2'd1; irw = mr; pcw = mr; end
            1:  begin asb = 2'd3; ill = (c == C_ILL); done = (c == C_ILL); end
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mwr = 1; iord = 1; done = mr; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rdst = 1; rw = 1; done = 1; end
            8:  begin asa = 1; aop = 2'd1; psrc = 2'd1; done = 1; pcwc = (c == C_BEQ); pcw = (c == C_BNE) && !z; end
            9:  begin psrc = 2'd2; pcw = 1; done = 1; end
            10: begin asa = 1; asb = 2'd2; end
            11: begin rw = 1; done = 1; end
            12: begin psrc = 2'd3; pcw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, psrc, done, ill, st[3:0]};
    endfunction

    function automatic logic [21:0] dut_vec();
        return {bus_if.pc_write, bus_if.pc_write_cond, bus_if.i_or_d, bus_if.mem_read, bus_if.mem_write,
                bus_if.ir_write, bus_if.reg_dst, bus_if.mem_to_reg, bus_if.reg_write, bus_if.alu_src_a,
                bus_if.alu_src_b, bus_if.alu_op, bus_if.pc_source, bus_if.instr_done, bus_if.illegal_op,
                bus_if.state};
    endfunction

    task automatic pick_random(output logic [5:0] op, output logic [5:0] fn);
        int r;
        r  = $urandom_range(0, 9);
        fn = 6'($urandom);
        case (r)
            0: begin op = 6'd0; if (fn == 6'd8) fn = 6'd32; end
            1: begin op = 6'd0; fn = 6'd8; end
            2: op = 6'd35;
            3: op = 6'd43;
            4: op = 6'd4;
            5: op = 6'd5;
            6: op = 6'd8;
            7: op = 6'd2;
            8: op = 6'($urandom);
            default: op = 6'h3f;
        endcase
    endtask

    // model advance at the edge, drive inputs 2 time units later, compare at the falling edge
    initial begin : model_and_compare
        int st;
        logic [21:0] ev, dv;
        logic [11:0] ent;
        seq = '{0};
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                seq = '{0}; idx = 0; lat = 0; waits = 0; icyc = 0;
            end else begin
                st = seq[idx];
                if ((st == 0 || st == 3 || st == 5) && !bus_if.mem_ready) begin
                    waits++;
                end else if (st == 0) begin
                    if (op_q.size() > 0) begin
                        ent = op_q.pop_front();
                        cur_op = ent[11:6];
                        cur_fn = ent[5:0];
                    end else begin
                        pick_random(cur_op, cur_fn);
                    end
                    cls = classify(cur_op, cur_fn);
                    lat = latency_of(cls);
                    seq = path_of(cls);
                    idx = 1;
                end else if (idx == seq.size() - 1) begin
                    seq = '{0}; idx = 0; lat = 0; waits = 0; icyc = 0;
                end else begin
                    idx++;
                end
            end
            #2;
            if (idx == 0) begin
                bus_if.opcode = 6'($urandom);
                bus_if.funct  = 6'($urandom);
            end else begin
                bus_if.opcode = cur_op;
                bus_if.funct  = cur_fn;
            end
            bus_if.mem_ready = (mr_q.size() > 0) ? mr_q.pop_front() : ($urandom_range(0, 3) != 0);
            bus_if.zero      = force_zero ? zero_val : 1'($urandom);
            @(negedge clk);
            if (reset_n) icyc++;
            ev = exp_vec(seq[idx], cls, bus_if.zero, bus_if.mem_ready, reset_n);
            dv = dut_vec();
            n_checks++;
            if (dv !== ev) begin
                n_fail++;
                $display("FAIL outputs t=%0t model_state=%0d got=%h want=%h", $time, seq[idx], dv, ev);
            end
            if (reset_n && lat > 0 && bus_if.instr_done === 1'b1)
                chk("instr_latency", 32'(icyc), 32'(lat + waits));
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        mr_q.delete();
        op_q.delete();
    endtask

    task automatic push_ready(input int n);
        repeat (n) mr_q.push_back(1'b1);
    endtask

    task automatic run_instr(input string name, input int max, output int cyc,
                             output int rw_n, output int m2r_n, output int mw_n);
        bit done = 0;
        cyc = 0; rw_n = 0; m2r_n = 0; mw_n = 0;
        while (!done && cyc < max) begin
            @(negedge clk);
            cyc++;
            rw_n  += int'(bus_if.reg_write);
            m2r_n += int'(bus_if.mem_to_reg);
            mw_n  += int'(bus_if.mem_write);
            if (bus_if.instr_done === 1'b1) begin
                done    = 1;
                s_pcw   = bus_if.pc_write;
                s_pcwc  = bus_if.pc_write_cond;
                s_psrc  = bus_if.pc_source;
                s_ill   = bus_if.illegal_op;
                s_state = bus_if.state;
            end
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin : directed
        int cyc, rw_n, m2r_n, mw_n, total, mw_total;
        bus_if.opcode = '0; bus_if.funct = '0; bus_if.zero = 1'b0; bus_if.mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", 32'(dut_vec()), 32'd0);

        // reset while stalled in MEM_RD
        do_reset();
        op_q.push_back({6'b100011, 6'd0});
        push_ready(3);
        repeat (8) mr_q.push_back(1'b0);
        repeat (4) @(negedge clk);
        chk("midstall_state", 32'(bus_if.state), 32'd3);
        chk("midstall_mem_read", 32'(bus_if.mem_read), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("midstall_reset_zero", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        mr_q.delete();
        @(negedge clk);
        chk("release_state", 32'(bus_if.state), 32'd0);
        chk("release_mem_read", 32'(bus_if.mem_read), 32'd1);

        // lw: 2 waits in FETCH, 1 in MEM_RD
        do_reset();
        op_q.push_back({6'b100011, 6'd0});
        mr_q = '{0, 0, 1, 1, 1, 0, 1, 1};
        run_instr("lw", 20, cyc, rw_n, m2r_n, mw_n);
        chk("lw_cycles", 32'(cyc), 32'd8);
        chk("lw_reg_write_once", 32'(rw_n), 32'd1);
        chk("lw_mem_to_reg_once", 32'(m2r_n), 32'd1);

        // branches
        force_zero = 1'b1;
        zero_val = 1'b1;
        do_reset();
        op_q.push_back({6'b000100, 6'd0});
        push_ready(4);
        run_instr("beq_z1", 10, cyc, rw_n, m2r_n, mw_n);
        chk("beq_cycles", 32'(cyc), 32'd3);
        chk("beq_pc_write_cond", 32'(s_pcwc), 32'd1);
        chk("beq_pc_source", 32'(s_psrc), 32'd1);

        do_reset();
        op_q.push_back({6'b000101, 6'd0});
        push_ready(4);
        run_instr("bne_z1", 10, cyc, rw_n, m2r_n, mw_n);
        chk("bne_z1_pc_write", 32'(s_pcw), 32'd0);
        chk("bne_z1_pc_write_cond", 32'(s_pcwc), 32'd0);

        zero_val = 1'b0;
        do_reset();
        op_q.push_back({6'b000101, 6'd0});
        push_ready(4);
        run_instr("bne_z0", 10, cyc, rw_n, m2r_n, mw_n);
        chk("bne_z0_pc_write", 32'(s_pcw), 32'd1);
        force_zero = 1'b0;

        // j and jr
        do_reset();
        op_q.push_back({6'b000010, 6'd0});
        push_ready(4);
        run_instr("j", 10, cyc, rw_n, m2r_n, mw_n);
        chk("j_cycles", 32'(cyc), 32'd3);
        chk("j_pc_source", 32'(s_psrc), 32'd2);
        chk("j_pc_write", 32'(s_pcw), 32'd1);

        do_reset();
        op_q.push_back({6'b000000, 6'b001000});
        push_ready(4);
        run_instr("jr", 10, cyc, rw_n, m2r_n, mw_n);
        chk("jr_cycles", 32'(cyc), 32'd3);
        chk("jr_pc_source", 32'(s_psrc), 32'd3);
        chk("jr_pc_write", 32'(s_pcw), 32'd1);

        // illegal opcode
        do_reset();
        op_q.push_back({6'b111111, 6'd0});
        push_ready(4);
        run_instr("illegal", 10, cyc, rw_n, m2r_n, mw_n);
        chk("illegal_cycles", 32'(cyc), 32'd2);
        chk("illegal_op_flag", 32'(s_ill), 32'd1);
        chk("illegal_in_decode", 32'(s_state), 32'd1);
        @(negedge clk);
        chk("illegal_back_to_fetch", 32'(bus_if.state), 32'd0);

        // back-to-back R-type, sw, addi with zero-wait memory
        do_reset();
        op_q.push_back({6'b000000, 6'b100000});
        op_q.push_back({6'b101011, 6'd0});
        op_q.push_back({6'b001000, 6'd0});
        push_ready(14);
        total = 0;
        mw_total = 0;
        run_instr("b2b_r", 10, cyc, rw_n, m2r_n, mw_n);
        total += cyc; mw_total += mw_n;
        chk("b2b_r_done_cycle", 32'(total), 32'd4);
        run_instr("b2b_sw", 10, cyc, rw_n, m2r_n, mw_n);
        total += cyc; mw_total += mw_n;
        chk("b2b_sw_done_cycle", 32'(total), 32'd8);
        run_instr("b2b_addi", 10, cyc, rw_n, m2r_n, mw_n);
        total += cyc; mw_total += mw_n;
        chk("b2b_addi_done_cycle", 32'(total), 32'd12);
        chk("b2b_mem_write_cycles", 32'(mw_total), 32'd1);

        // random instruction stream with random memory stalls and periodic resets
        repeat (8) begin
            do_reset();
            repeat (500) @(posedge clk);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS datapath. Sequences fetch, decode, execute, memory and writeback for each instruction and drives every datapath select and write-enable. This includes `pc_source`, which routes the jump target built from the shifted 26-bit jump field. Memory accesses use a `mem_ready` handshake, so variable-latency memory stalls the FSM in place.

## Interface
Parameters:
- `RESET_VECTOR_SEL`, default 0: reserved, must be 0; no functional effect.

Ports:
- `clk`  in  1  rising-edge clock; the only clock.
- `reset_n`  in  1  reset, synchronous, active-low.
- `opcode`  in  6  IR[31:26].
- `funct`  in  6  IR[5:0]; used only to detect `jr` (funct 001000).
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access this cycle.
- `pc_write`, `pc_write_cond`, `i_or_d`, `mem_read`, `mem_write`, `ir_write`  out  1 each  datapath enables and selects.
- `reg_dst`, `mem_to_reg`, `reg_write`, `alu_src_a`  out  1 each  datapath enables and selects.
- `alu_src_b`  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = {PC[31:28], jump field<<2}, 11 = reg A (`jr`).
- `instr_done`  out  1  one-cycle pulse in an instruction's final cycle.
- `illegal_op`  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- `state`  out  4  current state, for debug.

## Operation
- Supported opcodes:
  - R-type 000000; `jr` is R-type with funct 001000.
  - lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.
- State encodings:
  - FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6.
  - R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, JR 12.
  - Codes 13–15 are unused and go to FETCH on the next edge.
- Per-state outputs (anything not listed is 0):
  - FETCH: `mem_read`=1, `alu_src_b`=01, `ir_write`=`pc_write`=`mem_ready`. Holds FETCH until `mem_ready`, then goes to DECODE.
  - DECODE: `alu_src_b`=11; computes the branch target into ALUOut.
    - Next state by opcode: lw/sw → MEM_ADDR; R-type → R_EXEC (`jr` → JR); beq/bne → BRANCH; j → JUMP; addi → ADDI_EXEC.
    - Any other opcode → FETCH with `illegal_op`=1 and `instr_done`=1.
  - MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10. Next is MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: `mem_read`=1, `i_or_d`=1. Holds until `mem_ready`, then MEM_WB.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `instr_done`=1. Next is FETCH.
  - MEM_WR: `mem_write`=1, `i_or_d`=1, `instr_done`=`mem_ready`. Holds until `mem_ready`, then FETCH.
  - R_EXEC: `alu_src_a`=1, `alu_op`=10. Next is R_WB.
  - R_WB: `reg_dst`=1, `reg_write`=1, `instr_done`=1. Next is FETCH.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_source`=01, `instr_done`=1. Next is FETCH.
    - `pc_write_cond`=1 for beq.
    - For bne, the FSM asserts `pc_write`=~`zero` directly and `pc_write_cond`=0.
  - JUMP: `pc_source`=10, `pc_write`=1, `instr_done`=1. Next is FETCH.
  - JR: `pc_source`=11, `pc_write`=1, `instr_done`=1. Next is FETCH.
  - ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next is ADDI_WB.
  - ADDI_WB: `reg_write`=1, `instr_done`=1. Next is FETCH.
- Outputs are decoded combinationally from the state register; `mem_ready` and `zero` gate them where noted above.
- A `mem_ready` pulse outside FETCH, MEM_RD or MEM_WR is ignored.

## Timing
- Reset:
  - A clock edge with `reset_n`=0 sets state to FETCH, regardless of the current state, including mid-stall.
  - While `reset_n`=0, every output except `state` is forced to 0. `state` reads 0.
- Latency with zero-wait memory (`mem_ready` held high), in cycles: lw 5; R-type, sw, addi 4; beq, bne, j, jr 3; illegal 2.
- Each wait cycle on `mem_ready` adds exactly one cycle. Outputs stay stable throughout the stall.
- `instr_done` pulses exactly once per instruction.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode and funct constants;
  - the state enum with the fixed encodings above;
  - `pc_source`, `alu_src_b` and `alu_op` encoding constants.
- One sub-module, `mips_opcode_decode`: combinational, maps `opcode`/`funct` to a one-hot instruction class (rtype, jr, lw, sw, beq, bne, addi, j, illegal) consumed by the DECODE next-state logic.

## Test plan
- Reset mid-stall: assert reset in MEM_RD with `mem_ready`=0 → next cycle state=0, all outputs 0. Release → `mem_read`=1.
- lw with 2 wait cycles in FETCH and 1 in MEM_RD → `instr_done` 8 cycles after FETCH entry. `reg_write` and `mem_to_reg` high for exactly 1 cycle.
- beq with `zero`=1 → `pc_write_cond`=1, `pc_source`=01 in cycle 3. bne with `zero`=1 → `pc_write`=0. bne with `zero`=0 → `pc_write`=1.
- j → cycle 3 shows `pc_source`=10, `pc_write`=1. jr (000000/001000) → cycle 3 shows `pc_source`=11, `pc_write`=1.
- Illegal opcode 111111 → DECODE shows `illegal_op`=1 and `instr_done`=1, then FETCH.
- Back-to-back R-type, sw, addi with `mem_ready`=1 → `instr_done` at cycles 4, 8, 12. No spurious `mem_write` outside MEM_WR.
